data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Sequencing controller and two-master arbiter in front of the data memory interface. It shares the single data memory port between the core load/store unit (master 0) and an auxiliary master (master 1, e.g. a debug or DMA port). It serializes accesses, holds the command stable for the synchronous RAM read latency, and rejects misaligned requests before they reach memory. It returns a per-master completion pulse with read data.

## Interface
- `READ_LATENCY`, default 1: cycles from the access cycle to valid `mem_data_fetched`; legal range 1–7.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `m0_req`, `m1_req` in 1: request. Held with the command until the matching `gnt`.
- `m0_write`, `m1_write` in 1: 1 = store, 0 = load.
- `m0_format`, `m1_format` in 3: load/store format.
  - `[1:0]`: 00 byte, 01 half, 10 word.
  - `[2]`: unsigned load.
- `m0_address`, `m1_address` in 32: byte address.
- `m0_write_data`, `m1_write_data` in 32: store data, right-aligned.
- `m0_gnt`, `m1_gnt` out 1: one-cycle pulse; command captured.
- `m0_done`, `m1_done` out 1: one-cycle completion pulse.
- `m0_err`, `m1_err` out 1: valid with `done`; misaligned request, no memory access made.
- `m0_rdata`, `m1_rdata` out 32: load result; valid with `done` on a load.
- `mem_read_enable`, `mem_write_enable` out 1: to the data memory interface.
- `mem_data_format` out 3: to the data memory interface.
- `mem_address`, `mem_write_data` out 32: to the data memory interface.
- `mem_data_fetched` in 32: sign-fixed load data from the data memory interface.

## Operation
**States**
- IDLE: no transaction.
- ACCESS: command driven to memory.
- WAIT: read latency count.
- RESP: completion.

**IDLE**
- With at least one request, select a winner.
- Capture its write, format, address and data into command registers.
- Pulse its `gnt` next cycle.
- Enter ACCESS, or RESP if misaligned.
- Misaligned: half with `address[0]`=1, or word with `address[1:0]`≠0. Format `[1:0]`=11 is also treated as misaligned.

**ACCESS**
- Store: `mem_write_enable`=1 for exactly this cycle, gated by `~reset`; then RESP.
- Load: `mem_read_enable`=1; counter loaded with READ_LATENCY−1; then WAIT, or RESP directly if READ_LATENCY=1.

**WAIT**
- Hold address, format and `mem_read_enable`.
- Decrement the counter; go to RESP at 0.

**RESP**
- Pulse the winner's `done`.
- `err` is set if misaligned.
- On a load, `rdata` = `mem_data_fetched` sampled at the end of the last read-enabled cycle, registered.
- Return to IDLE.

**Arbitration**
- Only one transaction is in flight.
- The loser's `req` stays pending; there is no queue.
- A master may reissue `req` in the cycle after its `done`.

**Output rules**
- Outside ACCESS/WAIT, all `mem_*` outputs are 0.
- `mX_rdata` holds its last value between loads.

## Timing
- Load: `req` seen in IDLE at cycle N; `gnt` at N+1 (ACCESS); `done` at N+1+READ_LATENCY. Throughput: one load per READ_LATENCY+2 cycles.
- Store: `gnt` at N+1; memory written at N+1; `done` at N+2.
- Misaligned: `gnt` at N+1 (RESP); `done`+`err` at N+1; no `mem_*` activity.

**Reset values**
- State IDLE.
- All `gnt`/`done`/`err` 0.
- `rdata` 0.
- `mem_*` 0.
- Round-robin pointer favors master 0.

**Reset mid-operation**
- The transaction is aborted with no `done`.
- A store in its ACCESS cycle does not write, because `mem_write_enable` is gated by `reset`.
- Requesters must reissue.

**Simultaneous requests**
- Resolved per Configuration.
- A `req` arriving in the same cycle as another master's RESP is served from the following IDLE cycle.

## Configuration
- `DATA_ARBITER_ROUND_ROBIN_EN` defined: round-robin. On a tie, grant the master not granted last. The pointer updates only on `gnt`.
- Not defined: fixed priority, master 0 always wins ties. The pointer register is omitted.

## Structure
- Shared package `data_arbiter_pkg`:
  - state encoding (IDLE=0, ACCESS=1, WAIT=2, RESP=3);
  - format constants (FMT_BYTE=3'b000, FMT_HALF=3'b001, FMT_WORD=3'b010, FMT_BYTE_U=3'b100, FMT_HALF_U=3'b101);
  - master index constants.
- One sub-module, `data_arbiter_select`:
  - Inputs: both `req`s and the last-grant pointer.
  - Outputs: one-hot winner.
  - Macro-dependent policy is isolated here.

## Test plan
- m0 load word 0x00002004, READ_LATENCY=2, memory returns 0xDEADBEEF → `m0_gnt` at N+1, `m0_done` at N+3, `m0_rdata`=0xDEADBEEF, `m0_err`=0.
- m1 store byte 0xA5 at 0x00002003 → `mem_write_enable` high exactly one cycle with address 0x00002003, format 000; `m1_done` at N+2.
- m0 load half at 0x00002001 → `m0_done`+`m0_err` at N+1, `m0_rdata` unchanged, `mem_read_enable` never asserted.
- Both request every cycle → with macro, grants alternate m0, m1, m0, m1; without macro, m0 is always granted and m1 is never granted.
- `reset` asserted in the ACCESS cycle of an m1 store → `mem_write_enable`=0 that cycle, no `m1_done`, state IDLE next cycle.
- m0 load with `done` at cycle K, m0 reissues `req` at K+1 → `gnt` at K+2; no lost or duplicated `done`.

Source files
------------

// File: rtl/data_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter: FSM encoding,
// load/store format codes, master indices and the captured command record.
package data_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    localparam logic [2:0] FMT_BYTE   = 3'b000;
    localparam logic [2:0] FMT_HALF   = 3'b001;
    localparam logic [2:0] FMT_WORD   = 3'b010;
    localparam logic [2:0] FMT_BYTE_U = 3'b100;
    localparam logic [2:0] FMT_HALF_U = 3'b101;

    localparam logic MASTER_0 = 1'b0;
    localparam logic MASTER_1 = 1'b1;

    // Wide enough for READ_LATENCY-1 with READ_LATENCY up to 7.
    localparam int CNT_W = 3;

    typedef struct packed {
        logic        write;
        logic [2:0]  format;
        logic [31:0] address;
        logic [31:0] write_data;
    } mem_cmd_t;

    // Size code 2'b11 has no legal access, so it is rejected like a misalignment.
    function automatic logic is_misaligned(input logic [2:0] format, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        if (format[1:0] == FMT_BYTE[1:0]) bad = 1'b0;
        else if (format[1:0] == FMT_HALF[1:0]) bad = addr_lo[0];
        else if (format[1:0] == FMT_WORD[1:0]) bad = (addr_lo != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/data_arbiter_select.sv
// Two-master winner selection. DATA_ARBITER_ROUND_ROBIN_EN selects round-robin
// tie breaking; otherwise master 0 has fixed priority.
module data_arbiter_select
    import data_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] winner
);

`ifdef DATA_ARBITER_ROUND_ROBIN_EN
    always_comb begin
        winner = req;
        if (req == 2'b11) begin
            winner = (last_grant == MASTER_1) ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        winner = 2'b00;
        if (req[0])      winner = 2'b01;
        else if (req[1]) winner = 2'b10;
    end
`endif

endmodule

// File: rtl/data_memory_arbiter.sv
// Serializes master 0 (LSU) and master 1 (aux) onto the single data memory port.
// Optional round-robin arbitration via DATA_ARBITER_ROUND_ROBIN_EN.
module data_memory_arbiter
    import data_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [2:0]  m0_format,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_write_data,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [2:0]  m1_format,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_write_data,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [2:0]  mem_data_format,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_data_fetched
);

    arb_state_e       state_q, state_d;
    mem_cmd_t         cmd_q, cmd_d;
    logic             owner_q, owner_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [31:0]      m0_rdata_q, m0_rdata_d;
    logic [31:0]      m1_rdata_q, m1_rdata_d;

    mem_cmd_t   m0_cmd, m1_cmd, sel_cmd;
    logic [1:0] winner;
    logic       last_grant;
    logic       capture;
    logic       active;

`ifdef DATA_ARBITER_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign last_grant = last_q;
`else
    assign last_grant = MASTER_1;
`endif

    assign m0_cmd  = '{m0_write, m0_format, m0_address, m0_write_data};
    assign m1_cmd  = '{m1_write, m1_format, m1_address, m1_write_data};
    assign sel_cmd = winner[1] ? m1_cmd : m0_cmd;

    data_arbiter_select u_select (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .winner     (winner)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        owner_d    = owner_q;
        mis_d      = mis_q;
        cnt_d      = cnt_q;
        gnt_d      = 2'b00;
        capture    = 1'b0;
`ifdef DATA_ARBITER_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|winner) begin
                    cmd_d   = sel_cmd;
                    owner_d = winner[1] ? MASTER_1 : MASTER_0;
                    mis_d   = is_misaligned(sel_cmd.format, sel_cmd.address[1:0]);
                    gnt_d   = winner;
                    state_d = mis_d ? ST_RESP : ST_ACCESS;
`ifdef DATA_ARBITER_ROUND_ROBIN_EN
                    last_d  = owner_d;
`endif
                end
            end
            ST_ACCESS: begin
                if (cmd_q.write) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = CNT_W'(READ_LATENCY - 1);
                    if (READ_LATENCY == 1) begin
                        capture = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data is taken at the end of the last read-enabled cycle only.
    always_comb begin
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        if (capture) begin
            if (owner_q == MASTER_1) m1_rdata_d = mem_data_fetched;
            else                     m0_rdata_d = mem_data_fetched;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            owner_q    <= MASTER_0;
            mis_q      <= 1'b0;
            cnt_q      <= '0;
            gnt_q      <= 2'b00;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
`ifdef DATA_ARBITER_ROUND_ROBIN_EN
            last_q     <= MASTER_1;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            owner_q    <= owner_d;
            mis_q      <= mis_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
`ifdef DATA_ARBITER_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign active = (state_q == ST_ACCESS) || (state_q == ST_WAIT);

    // Gating by reset keeps an aborted store from reaching memory.
    assign mem_write_enable = (state_q == ST_ACCESS) && cmd_q.write && !reset;
    assign mem_read_enable  = active && !cmd_q.write;
    assign mem_data_format  = active ? cmd_q.format     : 3'b000;
    assign mem_address      = active ? cmd_q.address    : 32'd0;
    assign mem_write_data   = active ? cmd_q.write_data : 32'd0;

    assign m0_gnt   = gnt_q[0];
    assign m1_gnt   = gnt_q[1];
    assign m0_done  = (state_q == ST_RESP) && (owner_q == MASTER_0);
    assign m1_done  = (state_q == ST_RESP) && (owner_q == MASTER_1);
    assign m0_err   = m0_done && mis_q;
    assign m1_err   = m1_done && mis_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter at READ_LATENCY=2; arbitration
// expectations follow DATA_ARBITER_ROUND_ROBIN_EN.
module tb_data_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [2:0]  m0_format, m1_format;
    logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
    logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_read_enable, mem_write_enable;
    logic [2:0]  mem_data_format;
    logic [31:0] mem_address, mem_write_data, mem_data_fetched;

    int errors = 0;
    int checks = 0;
    int m0_done_cnt = 0;

    always #5 clock = ~clock;

    always @(negedge clock) if (m0_done) m0_done_cnt++;

    data_memory_arbiter #(.READ_LATENCY(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .m0_req           (m0_req),
        .m0_write         (m0_write),
        .m0_format        (m0_format),
        .m0_address       (m0_address),
        .m0_write_data    (m0_write_data),
        .m0_gnt           (m0_gnt),
        .m0_done          (m0_done),
        .m0_err           (m0_err),
        .m0_rdata         (m0_rdata),
        .m1_req           (m1_req),
        .m1_write         (m1_write),
        .m1_format        (m1_format),
        .m1_address       (m1_address),
        .m1_write_data    (m1_write_data),
        .m1_gnt           (m1_gnt),
        .m1_done          (m1_done),
        .m1_err           (m1_err),
        .m1_rdata         (m1_rdata),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_data_format  (mem_data_format),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_data_fetched (mem_data_fetched)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are then sampled at +3.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int k_start;
        logic [1:0] gseq [4];
        int gidx;
        int m1_grants;

        reset = 1'b1;
        m0_req = 0; m0_write = 0; m0_format = 3'b010; m0_address = 0; m0_write_data = 0;
        m1_req = 0; m1_write = 0; m1_format = 3'b010; m1_address = 0; m1_write_data = 0;
        mem_data_fetched = 32'h0;
        step();
        step();
        settle();
        chk("rst_gnt",  {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk("rst_done", {28'd0, m1_err, m0_err, m1_done, m0_done}, 32'd0);
        chk("rst_rdata0", m0_rdata, 32'd0);
        chk("rst_rdata1", m1_rdata, 32'd0);
        chk("rst_mem", {25'd0, mem_data_format, 2'b00, mem_read_enable, mem_write_enable}, 32'd0);
        chk("rst_addr", mem_address | mem_write_data, 32'd0);
        reset = 1'b0;

        // m0 load word, fetched data valid only in the last read cycle
        step();
        m0_req = 1; m0_write = 0; m0_format = 3'b010; m0_address = 32'h0000_2004;
        step();                                         // N+1 ACCESS
        m0_req = 0;
        mem_data_fetched = 32'h1111_1111;
        settle();
        chk("ld_gnt",  m0_gnt, 1'b1);
        chk("ld_ren",  mem_read_enable, 1'b1);
        chk("ld_addr", mem_address, 32'h0000_2004);
        chk("ld_fmt",  mem_data_format, 3'b010);
        step();                                         // N+2 WAIT
        mem_data_fetched = 32'hDEAD_BEEF;
        settle();
        chk("ld_wait_done", m0_done, 1'b0);
        chk("ld_wait_ren",  mem_read_enable, 1'b1);
        step();                                         // N+3 RESP
        mem_data_fetched = 32'h2222_2222;
        settle();
        chk("ld_done",  m0_done, 1'b1);
        chk("ld_err",   m0_err, 1'b0);
        chk("ld_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("ld_resp_ren", mem_read_enable, 1'b0);
        step();
        settle();
        chk("ld_idle_done", m0_done, 1'b0);

        // m1 store byte
        m1_req = 1; m1_write = 1; m1_format = 3'b000; m1_address = 32'h0000_2003; m1_write_data = 32'h0000_00A5;
        step();                                         // N+1 ACCESS
        m1_req = 0;
        settle();
        chk("st_gnt",  m1_gnt, 1'b1);
        chk("st_wen",  mem_write_enable, 1'b1);
        chk("st_ren",  mem_read_enable, 1'b0);
        chk("st_addr", mem_address, 32'h0000_2003);
        chk("st_fmt",  mem_data_format, 3'b000);
        chk("st_wdata", mem_write_data, 32'h0000_00A5);
        step();                                         // N+2 RESP
        settle();
        chk("st_wen_off", mem_write_enable, 1'b0);
        chk("st_done", m1_done, 1'b1);
        chk("st_err",  m1_err, 1'b0);
        step();
        settle();
        chk("st_idle_done", m1_done, 1'b0);

        // m0 misaligned half load
        m0_req = 1; m0_write = 0; m0_format = 3'b001; m0_address = 32'h0000_2001;
        step();                                         // N+1 RESP
        m0_req = 0;
        settle();
        chk("mis_gnt",  m0_gnt, 1'b1);
        chk("mis_done", m0_done, 1'b1);
        chk("mis_err",  m0_err, 1'b1);
        chk("mis_ren",  mem_read_enable, 1'b0);
        chk("mis_rdata", m0_rdata, 32'hDEAD_BEEF);
        step();
        settle();
        chk("mis_after_done", m0_done, 1'b0);
        chk("mis_after_ren",  mem_read_enable, 1'b0);

        // both masters request continuously, from a fresh pointer
        do_reset();
        m0_format = 3'b010; m0_address = 32'h0000_0100; m0_write = 0;
        m1_format = 3'b010; m1_address = 32'h0000_0200; m1_write = 0;
        m0_req = 1; m1_req = 1;
        gidx = 0;
        m1_grants = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (c == 15) begin
                m0_req = 0;
                m1_req = 0;
            end
            settle();
            if (m1_gnt) m1_grants++;
            if ((m0_gnt || m1_gnt) && gidx < 4) begin
                gseq[gidx] = {m1_gnt, m0_gnt};
                gidx++;
            end
        end
        chk("arb_count", gidx, 4);
`ifdef DATA_ARBITER_ROUND_ROBIN_EN
        chk("arb_g0", gseq[0], 2'b01);
        chk("arb_g1", gseq[1], 2'b10);
        chk("arb_g2", gseq[2], 2'b01);
        chk("arb_g3", gseq[3], 2'b10);
        chk("arb_m1_grants", m1_grants, 2);
`else
        chk("arb_g0", gseq[0], 2'b01);
        chk("arb_g1", gseq[1], 2'b01);
        chk("arb_g2", gseq[2], 2'b01);
        chk("arb_g3", gseq[3], 2'b01);
        chk("arb_m1_grants", m1_grants, 0);
`endif
        step();
        settle();
        chk("arb_drain_gnt", {m1_gnt, m0_gnt}, 2'b00);

        // reset during the ACCESS cycle of an m1 store
        m1_req = 1; m1_write = 1; m1_format = 3'b010; m1_address = 32'h0000_3000; m1_write_data = 32'h1234_5678;
        step();                                         // N+1 ACCESS
        m1_req = 0;
        reset = 1;
        settle();
        chk("rma_gnt", m1_gnt, 1'b1);
        chk("rma_wen", mem_write_enable, 1'b0);
        step();                                         // N+2 should be IDLE
        reset = 0;
        settle();
        chk("rma_done", m1_done, 1'b0);
        chk("rma_mem", {mem_read_enable, mem_write_enable}, 2'b00);
        m0_req = 1; m0_write = 0; m0_format = 3'b010; m0_address = 32'h0000_0040;
        step();
        m0_req = 0;
        settle();
        chk("rma_idle_gnt", m0_gnt, 1'b1);
        chk("rma_no_m1_done", m1_done, 1'b0);
        step();
        step();                                         // RESP
        step();                                         // IDLE
        settle();

        // back-to-back reissue right after done
        k_start = m0_done_cnt;
        mem_data_fetched = 32'hCAFE_0001;
        m0_req = 1; m0_address = 32'h0000_0044;
        step();                                         // ACCESS
        m0_req = 0;
        step();                                         // WAIT
        step();                                         // RESP = K
        settle();
        chk("rei_done_k", m0_done, 1'b1);
        chk("rei_rdata_k", m0_rdata, 32'hCAFE_0001);
        step();                                         // K+1 IDLE
        m0_req = 1; m0_address = 32'h0000_0048;
        mem_data_fetched = 32'hCAFE_0002;
        settle();
        chk("rei_k1_gnt",  m0_gnt, 1'b0);
        chk("rei_k1_done", m0_done, 1'b0);
        step();                                         // K+2 ACCESS
        m0_req = 0;
        settle();
        chk("rei_k2_gnt", m0_gnt, 1'b1);
        step();
        step();                                         // RESP
        settle();
        chk("rei_done2", m0_done, 1'b1);
        chk("rei_rdata2", m0_rdata, 32'hCAFE_0002);
        step();
        step();
        settle();
        chk("rei_done_count", m0_done_cnt - k_start, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
